// File: rtl/mul_rs_scheduler.sv
// Shares one multiplier among NUM_RS reservation stations: round-robin issue,
// tag pipe matched to the multiplier latency, and a credit-guarded CDB result queue.
module mul_rs_scheduler #(
    parameter int NUM_RS    = 3,
    parameter int TAG_W     = 4,
    parameter int MUL_LAT   = 0,
    parameter int OUT_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RS-1:0]         rs_valid,
    input  logic [NUM_RS*32-1:0]      rs_a,
    input  logic [NUM_RS*32-1:0]      rs_b,
    input  logic [NUM_RS*TAG_W-1:0]   rs_tag,
    output logic [NUM_RS-1:0]         rs_grant,
    input  logic                      flush,
    output logic [31:0]               mul_a,
    output logic [31:0]               mul_b,
    input  logic [63:0]               mul_p,
    output logic                      cdb_req,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [63:0]               cdb_data,
    input  logic                      cdb_grant,
    output logic                      busy
);
    localparam int PTR_W = $clog2(NUM_RS);
    localparam int QP_W  = $clog2(OUT_DEPTH);
    localparam int QC_W  = $clog2(OUT_DEPTH + 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic             found;
    logic             issue_ok;
    logic             do_issue;
    logic             do_push;
    logic             do_pop;
    logic [3:0]       occupancy;

    logic [MUL_LAT:0] stage_valid;
    logic [TAG_W-1:0] stage_tag [MUL_LAT+1];

    logic [TAG_W-1:0] q_tag  [OUT_DEPTH];
    logic [63:0]      q_data [OUT_DEPTH];
    logic [QP_W-1:0]  q_head;
    logic [QP_W-1:0]  q_tail;
    logic [QC_W-1:0]  q_count;

    function automatic logic [QP_W-1:0] ptr_next(input logic [QP_W-1:0] p);
        return (p == QP_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every issued op owns a queue slot until popped, so in-flight plus queued
    // work may never exceed the queue depth; same-cycle pops are not credited.
    always_comb begin
        occupancy = 4'(q_count);
        for (int i = 0; i <= MUL_LAT; i++) begin
            occupancy = occupancy + 4'(stage_valid[i]);
        end
        issue_ok = occupancy < 4'(OUT_DEPTH);
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_RS; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_RS);
            if (!found && rs_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        do_issue = issue_ok && !flush && found;
        rs_grant = '0;
        if (do_issue) begin
            rs_grant[win] = 1'b1;
        end
    end

    // CDB handshake: the head is offered while cdb_req is high and leaves the
    // queue on any cycle where cdb_req and cdb_grant are both high.
    assign do_push  = stage_valid[MUL_LAT] && !flush;
    assign do_pop   = (q_count != '0) && cdb_grant;
    assign cdb_req  = (q_count != '0);
    assign cdb_tag  = cdb_req ? q_tag[q_head]  : '0;
    assign cdb_data = cdb_req ? q_data[q_head] : '0;
    assign busy     = (|stage_valid) || cdb_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= PTR_W'(NUM_RS - 1);
            mul_a       <= '0;
            mul_b       <= '0;
            stage_valid <= '0;
            for (int i = 0; i <= MUL_LAT; i++) begin
                stage_tag[i] <= '0;
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                q_tag[i]  <= '0;
                q_data[i] <= '0;
            end
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (do_issue) begin
                rr_ptr       <= win;
                mul_a        <= rs_a[int'(win)*32 +: 32];
                mul_b        <= rs_b[int'(win)*32 +: 32];
                stage_tag[0] <= rs_tag[int'(win)*TAG_W +: TAG_W];
            end
            for (int i = 1; i <= MUL_LAT; i++) begin
                stage_tag[i] <= stage_tag[i-1];
            end

            if (flush) begin
                stage_valid <= '0;
                q_head      <= '0;
                q_tail      <= '0;
                q_count     <= '0;
            end else begin
                stage_valid[0] <= do_issue;
                for (int i = 1; i <= MUL_LAT; i++) begin
                    stage_valid[i] <= stage_valid[i-1];
                end
                assert (!(do_push && !do_pop && q_count == QC_W'(OUT_DEPTH)));
                if (do_push) begin
                    q_tag[q_tail]  <= stage_tag[MUL_LAT];
                    q_data[q_tail] <= mul_p;
                    q_tail         <= ptr_next(q_tail);
                end
                if (do_pop) begin
                    q_head <= ptr_next(q_head);
                end
                case ({do_push, do_pop})
                    2'b10:   q_count <= q_count + 1'b1;
                    2'b01:   q_count <= q_count - 1'b1;
                    default: q_count <= q_count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mul_rs_scheduler.sv
// Scoreboard bench for mul_rs_scheduler: an outstanding-op credit model predicts
// grants and queues expected {tag, product}; a negedge monitor checks the CDB.
module tb_mul_rs_scheduler;
    localparam int NUM_RS    = 3;
    localparam int TAG_W     = 4;
    localparam int MUL_LAT   = 0;
    localparam int OUT_DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_RS-1:0]       rs_valid;
    logic [NUM_RS*32-1:0]    rs_a;
    logic [NUM_RS*32-1:0]    rs_b;
    logic [NUM_RS*TAG_W-1:0] rs_tag;
    logic [NUM_RS-1:0]       rs_grant;
    logic                    flush;
    logic [31:0]             mul_a;
    logic [31:0]             mul_b;
    logic [63:0]             mul_p;
    logic                    cdb_req;
    logic [TAG_W-1:0]        cdb_tag;
    logic [63:0]             cdb_data;
    logic                    cdb_grant;
    logic                    busy;

    int errors = 0;
    int checks = 0;

    logic [TAG_W+63:0] exp_q[$];
    logic [TAG_W+63:0] exp_head;
    logic [NUM_RS-1:0] m_grant;
    int                m_rr;
    int                m_win;
    int                outstanding;

    mul_rs_scheduler #(
        .NUM_RS(NUM_RS), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rs_valid(rs_valid), .rs_a(rs_a), .rs_b(rs_b),
        .rs_tag(rs_tag), .rs_grant(rs_grant), .flush(flush), .mul_a(mul_a),
        .mul_b(mul_b), .mul_p(mul_p), .cdb_req(cdb_req), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_grant(cdb_grant), .busy(busy)
    );

    // External combinational multiplier (MUL_LAT = 0).
    assign mul_p = {32'b0, mul_a} * {32'b0, mul_b};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
        rs_a[i*32 +: 32]       = a;
        rs_b[i*32 +: 32]       = b;
        rs_tag[i*TAG_W +: TAG_W] = t;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rs_grant"}, 64'(rs_grant), 64'd0);
        check({pfx, "_mul_a"},    64'(mul_a),    64'd0);
        check({pfx, "_mul_b"},    64'(mul_b),    64'd0);
        check({pfx, "_cdb_req"},  64'(cdb_req),  64'd0);
        check({pfx, "_cdb_tag"},  64'(cdb_tag),  64'd0);
        check({pfx, "_cdb_data"}, cdb_data,      64'd0);
        check({pfx, "_busy"},     64'(busy),     64'd0);
    endtask

    // Reference model: an op holds one credit from grant until its CDB pop.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            m_rr        = NUM_RS - 1;
        end else begin
            m_grant = '0;
            m_win   = -1;
            if (outstanding < OUT_DEPTH && !flush && rs_valid != '0) begin
                for (int k = 1; k <= NUM_RS; k++) begin
                    if (m_win < 0 && rs_valid[(m_rr + k) % NUM_RS]) begin
                        m_win = (m_rr + k) % NUM_RS;
                    end
                end
                m_grant[m_win] = 1'b1;
            end
            check("grant", 64'(rs_grant), 64'(m_grant));

            if (cdb_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cdb_spurious: got tag %h data %h expected no request at %0t",
                             cdb_tag, cdb_data, $time);
                end else begin
                    exp_head = exp_q[0];
                    check("cdb_tag",  64'(cdb_tag), 64'(exp_head[TAG_W+63:64]));
                    check("cdb_data", cdb_data,     exp_head[63:0]);
                    if (cdb_grant) begin
                        void'(exp_q.pop_front());
                        outstanding--;
                    end
                end
            end

            if (m_win >= 0) begin
                exp_q.push_back({rs_tag[m_win*TAG_W +: TAG_W],
                                 {32'b0, rs_a[m_win*32 +: 32]} * {32'b0, rs_b[m_win*32 +: 32]}});
                m_rr = m_win;
                outstanding++;
            end

            if (flush) begin
                exp_q.delete();
                outstanding = 0;
            end
        end
    end

    initial begin
        rst = 1'b1; rs_valid = '0; rs_a = '0; rs_b = '0; rs_tag = '0;
        flush = 1'b0; cdb_grant = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        // Single op: grant in cycle 0, operands in 1, result in 2, idle in 3.
        cdb_grant = 1'b1;
        set_rs(1, 32'd7, 32'd6, 4'd5);
        rs_valid = 3'b010;
        @(negedge clk);
        check("single_grant", 64'(rs_grant), 64'b010);
        tick();
        rs_valid = '0;
        @(negedge clk);
        check("single_mul_a", 64'(mul_a), 64'd7);
        check("single_mul_b", 64'(mul_b), 64'd6);
        tick();
        @(negedge clk);
        check("single_req",  64'(cdb_req), 64'd1);
        check("single_tag",  64'(cdb_tag),  64'd5);
        check("single_data", cdb_data,      64'h2A);
        tick();
        @(negedge clk);
        check("single_busy", 64'(busy), 64'd0);
        tick();

        // Round robin with all stations requesting.
        for (int i = 0; i < NUM_RS; i++) set_rs(i, 32'(100 + i), 32'(3 + i), 4'(8 + i));
        rs_valid = '1;
        repeat (12) tick();
        rs_valid = '0;
        repeat (4) tick();

        // Backpressure: queue fills, head holds, then drains in order.
        cdb_grant = 1'b0;
        set_rs(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
        rs_valid = 3'b001;
        tick();
        set_rs(0, 32'd2, 32'd3, 4'd2);
        tick();
        rs_valid = '1;
        repeat (5) begin
            @(negedge clk);
            check("bp_no_grant", 64'(rs_grant), 64'd0);
            check("bp_req",      64'(cdb_req),  64'd1);
            check("bp_hold",     cdb_data,      64'hFFFF_FFFE_0000_0001);
            tick();
        end
        rs_valid  = '0;
        cdb_grant = 1'b1;
        @(negedge clk);
        check("bp_first", cdb_data, 64'hFFFF_FFFE_0000_0001);
        tick();
        @(negedge clk);
        check("bp_second", cdb_data, 64'd6);
        repeat (3) tick();

        // Flush one cycle after a grant.
        set_rs(2, 32'd5, 32'd5, 4'd9);
        rs_valid = 3'b100;
        @(negedge clk);
        check("flush_pre_grant", 64'(rs_grant), 64'b100);
        tick();
        rs_valid = '1;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_no_grant", 64'(rs_grant), 64'd0);
        tick();
        flush    = 1'b0;
        rs_valid = 3'b001;
        set_rs(0, 32'd11, 32'd13, 4'd3);
        @(negedge clk);
        check("flush_busy",       64'(busy),     64'd0);
        check("flush_req",        64'(cdb_req),  64'd0);
        check("flush_next_grant", 64'(rs_grant), 64'b001);
        tick();
        rs_valid = '0;
        repeat (4) tick();

        // Simultaneous push and pop with one entry queued.
        cdb_grant = 1'b0;
        set_rs(0, 32'd21, 32'd2, 4'd6);
        rs_valid = 3'b001;
        tick();
        set_rs(1, 32'd33, 32'd3, 4'd7);
        rs_valid = 3'b010;
        tick();
        rs_valid  = '0;
        cdb_grant = 1'b1;
        @(negedge clk);
        check("pp_old_head", 64'(cdb_tag), 64'd6);
        tick();
        cdb_grant = 1'b0;
        @(negedge clk);
        check("pp_req",  64'(cdb_req), 64'd1);
        check("pp_tag",  64'(cdb_tag), 64'd7);
        check("pp_data", cdb_data,     64'd99);
        tick();
        cdb_grant = 1'b1;
        repeat (3) tick();

        // Reset with two ops in flight.
        cdb_grant = 1'b0;
        set_rs(0, 32'd4, 32'd4, 4'd1);
        set_rs(1, 32'd8, 32'd8, 4'd2);
        rs_valid = 3'b001;
        tick();
        rs_valid = 3'b010;
        tick();
        rs_valid = '0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        rs_valid = '1;
        @(negedge clk);
        check("midrst_first_grant", 64'(rs_grant), 64'b001);
        tick();
        rs_valid  = '0;
        cdb_grant = 1'b1;
        repeat (4) tick();

        // Randomized traffic with backpressure and occasional flush.
        for (int n = 0; n < 400; n++) begin
            rs_valid = NUM_RS'($urandom_range(0, (1 << NUM_RS) - 1));
            for (int i = 0; i < NUM_RS; i++) set_rs(i, rnd_op(), rnd_op(), TAG_W'($urandom));
            cdb_grant = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush     = 1'b0;
        rs_valid  = '0;
        cdb_grant = 1'b1;
        for (int n = 0; n < 50 && (exp_q.size() != 0 || busy); n++) tick();
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_busy",  64'(busy),         64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
